// File: rtl/difftest_commit_queue_if.sv
// Signal bundle between the retire stage, difftest_commit_queue and the Difftest sinks.
// slave is the queue's view; master is the pipeline/difftest side.
interface difftest_commit_queue_if #(
  parameter int NCH  = 2,
  parameter int XLEN = 64
);
  logic [NCH-1:0]      in_valid;
  logic                in_ready;
  logic [NCH*XLEN-1:0] in_pc;
  logic [NCH*32-1:0]   in_inst;
  logic [NCH-1:0]      in_wen;
  logic [NCH*5-1:0]    in_wdest;
  logic [NCH*XLEN-1:0] in_wdata;
  logic [NCH-1:0]      in_skip;
  logic [7:0]          trap_code_i;

  logic                cmt_valid;
  logic [XLEN-1:0]     cmt_pc;
  logic [31:0]         cmt_inst;
  logic                cmt_wen;
  logic [7:0]          cmt_wdest;
  logic [XLEN-1:0]     cmt_wdata;
  logic                cmt_skip;

  logic                trap_valid;
  logic [7:0]          trap_code;
  logic [XLEN-1:0]     trap_pc;
  logic [63:0]         cycle_cnt;
  logic [63:0]         instr_cnt;
  logic                wdog_timeout;

  modport slave (
    input  in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata, in_skip, trap_code_i,
    output in_ready,
    output cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata, cmt_skip,
    output trap_valid, trap_code, trap_pc, cycle_cnt, instr_cnt, wdog_timeout
  );

  modport master (
    output in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata, in_skip, trap_code_i,
    input  in_ready,
    input  cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata, cmt_skip,
    input  trap_valid, trap_code, trap_pc, cycle_cnt, instr_cnt, wdog_timeout
  );
endinterface

// File: rtl/difftest_commit_queue.sv
// Difftest commit collector: buffers up to NCH retired instructions per cycle, replays
// one per cycle on registered outputs and halts on trap. Optional: COMMIT_WDOG_EN.
module difftest_commit_queue #(
  parameter int              NCH      = 2,
  parameter int              DEPTH    = 8,
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] PC_START = XLEN'(64'h8000_0000)
) (
  input logic                    clock,
  input logic                    reset,
  difftest_commit_queue_if.slave bus
);
  // state      | meaning
  // ST_RUN     | accepting retire groups, draining one commit per cycle
  // ST_TRAPPED | trap committed; queue frozen, only reset leaves

  localparam int         AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         CW          = $clog2(DEPTH + 1);
  localparam logic [6:0] TRAP_OPCODE = 7'h6b;

  if (NCH < 1 || NCH > 4 || DEPTH < 2 * NCH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("difftest_commit_queue: illegal NCH/DEPTH combination");
  end

  typedef enum logic {ST_RUN, ST_TRAPPED} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            wen;
    logic [4:0]      wdest;
    logic [XLEN-1:0] wdata;
    logic            skip;
  } entry_t;

  state_t          state_q, state_d;
  entry_t          mem [DEPTH];
  entry_t          lane_e [NCH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, n_enq, enq_cnt;
  logic            in_ready_c, deq, is_trap;

  logic            cmt_valid_q, cmt_wen_q, cmt_skip_q, trap_valid_q, wdog_q;
  logic [XLEN-1:0] cmt_pc_q, cmt_wdata_q, trap_pc_q;
  logic [31:0]     cmt_inst_q;
  logic [7:0]      cmt_wdest_q, trap_code_q;
  logic [63:0]     cycle_cnt_q, instr_cnt_q;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      lane_e[i].pc    = bus.in_pc[i*XLEN +: XLEN];
      lane_e[i].inst  = bus.in_inst[i*32 +: 32];
      lane_e[i].wen   = bus.in_wen[i];
      lane_e[i].wdest = bus.in_wdest[i*5 +: 5];
      lane_e[i].wdata = bus.in_wdata[i*XLEN +: XLEN];
      lane_e[i].skip  = bus.in_skip[i];
    end
  end

  always_comb begin
    n_enq = '0;
    for (int i = 0; i < NCH; i++) begin
      n_enq = n_enq + CW'(bus.in_valid[i]);
    end
  end

  // Readiness ignores a same-cycle dequeue so in_ready depends only on registered state.
  assign in_ready_c = (state_q == ST_RUN) && ((DEPTH - int'(count_q)) >= NCH);
  assign enq_cnt    = in_ready_c ? n_enq : '0;
  assign deq        = (state_q == ST_RUN) && (count_q != '0);
  assign head       = mem[rd_ptr_q];
  assign is_trap    = deq && (head.inst[6:0] == TRAP_OPCODE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (is_trap) state_d = ST_TRAPPED;
      ST_TRAPPED: state_d = ST_TRAPPED;
      default:    state_d = ST_RUN;
    endcase
  end

  // Lanes are contiguous from lane 0, so lane i lands at wr_ptr + i.
  always_ff @(posedge clock) begin
    if (!reset && in_ready_c) begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.in_valid[i]) begin
          mem[wr_ptr_q + AW'(i)] <= lane_e[i];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(enq_cnt);
      if (deq) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + enq_cnt - CW'(deq);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmt_valid_q  <= 1'b0;
      cmt_pc_q     <= '0;
      cmt_inst_q   <= '0;
      cmt_wen_q    <= 1'b0;
      cmt_wdest_q  <= '0;
      cmt_wdata_q  <= '0;
      cmt_skip_q   <= 1'b0;
      trap_valid_q <= 1'b0;
      trap_code_q  <= '0;
      trap_pc_q    <= '0;
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
    end else begin
      cmt_valid_q  <= deq;
      trap_valid_q <= is_trap;
      cycle_cnt_q  <= cycle_cnt_q + 64'd1;
      if (deq) begin
        cmt_pc_q    <= head.pc;
        cmt_inst_q  <= head.inst;
        cmt_wen_q   <= head.wen;
        cmt_wdest_q <= {3'b000, head.wdest};
        cmt_wdata_q <= head.wdata;
        cmt_skip_q  <= head.skip || (head.pc == PC_START);
        instr_cnt_q <= instr_cnt_q + 64'd1;
      end
      if (is_trap) begin
        trap_pc_q   <= head.pc;
        trap_code_q <= bus.trap_code_i;
      end
    end
  end

`ifdef COMMIT_WDOG_EN
  logic [15:0] wdog_cnt_q, wdog_cnt_d;

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (cmt_valid_q) begin
      wdog_cnt_d = '0;
    end else if (state_q == ST_RUN && wdog_cnt_q != 16'hFFFF) begin
      wdog_cnt_d = wdog_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_cnt_q <= '0;
      wdog_q     <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      if (wdog_cnt_d == 16'hFFFF) wdog_q <= 1'b1;
    end
  end
`else
  assign wdog_q = 1'b0;
`endif

`ifndef SYNTHESIS
  logic [NCH:0] valid_ext;
  assign valid_ext = {1'b0, bus.in_valid};

  always_ff @(posedge clock) begin
    if (!reset && in_ready_c) begin
      assert (((valid_ext + (NCH+1)'(1)) & valid_ext) == '0)
        else $error("difftest_commit_queue: non-contiguous in_valid %b", bus.in_valid);
    end
  end
`endif

  assign bus.in_ready     = in_ready_c;
  assign bus.cmt_valid    = cmt_valid_q;
  assign bus.cmt_pc       = cmt_pc_q;
  assign bus.cmt_inst     = cmt_inst_q;
  assign bus.cmt_wen      = cmt_wen_q;
  assign bus.cmt_wdest    = cmt_wdest_q;
  assign bus.cmt_wdata    = cmt_wdata_q;
  assign bus.cmt_skip     = cmt_skip_q;
  assign bus.trap_valid   = trap_valid_q;
  assign bus.trap_code    = trap_code_q;
  assign bus.trap_pc      = trap_pc_q;
  assign bus.cycle_cnt    = cycle_cnt_q;
  assign bus.instr_cnt    = instr_cnt_q;
  assign bus.wdog_timeout = wdog_q;
endmodule

// File: tb/tb_difftest_commit_queue.sv
// Directed self-checking bench for difftest_commit_queue (NCH=2, DEPTH=8, XLEN=64).
`timescale 1ns/1ps
module tb_difftest_commit_queue;
  localparam int          NCH      = 2;
  localparam int          DEPTH    = 8;
  localparam int          XLEN     = 64;
  localparam logic [63:0] PC_START = 64'h8000_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  difftest_commit_queue_if #(.NCH(NCH), .XLEN(XLEN)) bus();

  difftest_commit_queue #(
    .NCH(NCH), .DEPTH(DEPTH), .XLEN(XLEN), .PC_START(PC_START)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic clear_inputs();
    bus.in_valid    = '0;
    bus.in_pc       = '0;
    bus.in_inst     = '0;
    bus.in_wen      = '0;
    bus.in_wdest    = '0;
    bus.in_wdata    = '0;
    bus.in_skip     = '0;
    bus.trap_code_i = '0;
  endtask

  task automatic set_lane(input int i, input logic [63:0] pc, input logic [31:0] inst,
                          input logic wen, input logic [4:0] wdest, input logic [63:0] wdata,
                          input logic skip);
    bus.in_pc[i*XLEN +: XLEN]    = pc;
    bus.in_inst[i*32 +: 32]      = inst;
    bus.in_wen[i]                = wen;
    bus.in_wdest[i*5 +: 5]       = wdest;
    bus.in_wdata[i*XLEN +: XLEN] = wdata;
    bus.in_skip[i]               = skip;
  endtask

  // Leaves the bench at a falling edge with two reset edges applied.
  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.cmt_valid !== 1'b0) begin errors++; $display("FAIL reset_cmt_valid got %0b want 0", bus.cmt_valid); end
    checks++; if (bus.trap_valid !== 1'b0) begin errors++; $display("FAIL reset_trap_valid got %0b want 0", bus.trap_valid); end
    checks++; if (bus.cmt_pc !== 64'd0) begin errors++; $display("FAIL reset_cmt_pc got %h want 0", bus.cmt_pc); end
    checks++; if (bus.cycle_cnt !== 64'd0) begin errors++; $display("FAIL reset_cycle_cnt got %0d want 0", bus.cycle_cnt); end
    checks++; if (bus.instr_cnt !== 64'd0) begin errors++; $display("FAIL reset_instr_cnt got %0d want 0", bus.instr_cnt); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
    checks++; if (bus.wdog_timeout !== 1'b0) begin errors++; $display("FAIL reset_wdog got %0b want 0", bus.wdog_timeout); end
  endtask

  task automatic test_basic();
    do_reset();
    set_lane(0, 64'h8000_0000, 32'h0000_0013, 1'b0, 5'd0, 64'd0, 1'b0);
    set_lane(1, 64'h8000_0004, 32'h0050_0093, 1'b1, 5'd1, 64'd5, 1'b0);
    bus.in_valid = 2'b11;
    @(negedge clock);
    clear_inputs();
    checks++; if (bus.cmt_valid !== 1'b0) begin errors++; $display("FAIL basic_latency got %0b want 0", bus.cmt_valid); end
    @(negedge clock);
    checks++; if (bus.cmt_valid !== 1'b1 || bus.cmt_pc !== 64'h8000_0000) begin errors++; $display("FAIL basic_rec0 got v=%0b pc=%h want v=1 pc=80000000", bus.cmt_valid, bus.cmt_pc); end
    checks++; if (bus.cmt_skip !== 1'b1) begin errors++; $display("FAIL basic_rec0_skip got %0b want 1", bus.cmt_skip); end
    checks++; if (bus.instr_cnt !== 64'd1) begin errors++; $display("FAIL basic_instr_cnt1 got %0d want 1", bus.instr_cnt); end
    @(negedge clock);
    checks++; if (bus.cmt_valid !== 1'b1 || bus.cmt_pc !== 64'h8000_0004) begin errors++; $display("FAIL basic_rec1 got v=%0b pc=%h want v=1 pc=80000004", bus.cmt_valid, bus.cmt_pc); end
    checks++; if (bus.cmt_inst !== 32'h0050_0093) begin errors++; $display("FAIL basic_rec1_inst got %h want 00500093", bus.cmt_inst); end
    checks++; if (bus.cmt_wen !== 1'b1 || bus.cmt_wdest !== 8'd1 || bus.cmt_wdata !== 64'd5) begin errors++; $display("FAIL basic_rec1_wb got wen=%0b wdest=%0d wdata=%0d want 1/1/5", bus.cmt_wen, bus.cmt_wdest, bus.cmt_wdata); end
    checks++; if (bus.cmt_skip !== 1'b0) begin errors++; $display("FAIL basic_rec1_skip got %0b want 0", bus.cmt_skip); end
    checks++; if (bus.instr_cnt !== 64'd2) begin errors++; $display("FAIL basic_instr_cnt2 got %0d want 2", bus.instr_cnt); end
    checks++; if (bus.cycle_cnt !== 64'd3) begin errors++; $display("FAIL basic_cycle_cnt got %0d want 3", bus.cycle_cnt); end
    @(negedge clock);
    checks++; if (bus.cmt_valid !== 1'b0 || bus.cmt_pc !== 64'h8000_0004) begin errors++; $display("FAIL basic_hold got v=%0b pc=%h want v=0 pc=80000004", bus.cmt_valid, bus.cmt_pc); end
  endtask

  // Streams 8 groups with a reference occupancy model; alternate selects 1,2,1,2 lanes.
  task automatic run_stream(input string tag, input bit alternate);
    logic [63:0] exp_q[$];
    logic [63:0] pc_next, exp_pc;
    int mcount, g, iter, lanes, total;
    bit pend_deq, deq, exp_ready;
    mcount = 0; g = 0; iter = 0; total = 0; pend_deq = 1'b0;
    pc_next = 64'h8000_1000;
    do_reset();
    while ((g < 8 || exp_q.size() > 0) && iter < 200) begin
      checks++;
      if (pend_deq) begin
        exp_pc = exp_q.pop_front();
        if (bus.cmt_valid !== 1'b1 || bus.cmt_pc !== exp_pc || bus.cmt_skip !== 1'b0) begin
          errors++; $display("FAIL %s_order iter %0d got v=%0b pc=%h skip=%0b want v=1 pc=%h skip=0", tag, iter, bus.cmt_valid, bus.cmt_pc, bus.cmt_skip, exp_pc);
        end
      end else if (bus.cmt_valid !== 1'b0) begin
        errors++; $display("FAIL %s_idle iter %0d got v=%0b want 0", tag, iter, bus.cmt_valid);
      end
      exp_ready = (DEPTH - mcount) >= NCH;
      checks++; if (bus.in_ready !== exp_ready) begin errors++; $display("FAIL %s_in_ready iter %0d got %0b want %0b", tag, iter, bus.in_ready, exp_ready); end
      clear_inputs();
      lanes = (alternate && (g % 2 == 0)) ? 1 : 2;
      if (g < 8) begin
        set_lane(0, pc_next, 32'h0000_0013, 1'b0, 5'd0, 64'd0, 1'b0);
        if (lanes == 2) set_lane(1, pc_next + 64'd4, 32'h0000_0013, 1'b0, 5'd0, 64'd0, 1'b0);
        bus.in_valid = (lanes == 2) ? 2'b11 : 2'b01;
      end
      deq = (mcount > 0);
      if (g < 8 && exp_ready) begin
        exp_q.push_back(pc_next);
        if (lanes == 2) exp_q.push_back(pc_next + 64'd4);
        pc_next = pc_next + 64'(4 * lanes);
        mcount += lanes;
        total += lanes;
        g++;
      end
      if (deq) mcount--;
      pend_deq = deq;
      @(negedge clock);
      iter++;
    end
    clear_inputs();
    checks++; if (iter >= 200) begin errors++; $display("FAIL %s_timeout got %0d iterations want <200", tag, iter); end
    checks++; if (bus.instr_cnt !== 64'(total)) begin errors++; $display("FAIL %s_instr_cnt got %0d want %0d", tag, bus.instr_cnt, total); end
  endtask

  task automatic test_burst();
    run_stream("burst", 1'b0);
  endtask

  task automatic test_alternate();
    run_stream("alt", 1'b1);
  endtask

  task automatic test_trap();
    do_reset();
    set_lane(0, 64'h8000_0010, 32'h0000_006b, 1'b0, 5'd0, 64'd0, 1'b0);
    set_lane(1, 64'h8000_0014, 32'h0000_0013, 1'b0, 5'd0, 64'd0, 1'b0);
    bus.in_valid = 2'b11;
    bus.trap_code_i = 8'h00;
    @(negedge clock);
    bus.in_valid = 2'b00;
    checks++; if (bus.trap_valid !== 1'b0) begin errors++; $display("FAIL trap_early got %0b want 0", bus.trap_valid); end
    @(negedge clock);
    checks++; if (bus.cmt_valid !== 1'b1 || bus.cmt_pc !== 64'h8000_0010 || bus.cmt_inst !== 32'h0000_006b) begin errors++; $display("FAIL trap_commit got v=%0b pc=%h inst=%h want 1/80000010/0000006b", bus.cmt_valid, bus.cmt_pc, bus.cmt_inst); end
    checks++; if (bus.trap_valid !== 1'b1 || bus.trap_pc !== 64'h8000_0010 || bus.trap_code !== 8'h00) begin errors++; $display("FAIL trap_pulse got v=%0b pc=%h code=%h want 1/80000010/00", bus.trap_valid, bus.trap_pc, bus.trap_code); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL trap_in_ready got %0b want 0", bus.in_ready); end
    set_lane(0, 64'h8000_0040, 32'h0000_0013, 1'b0, 5'd0, 64'd0, 1'b0);
    set_lane(1, 64'h8000_0044, 32'h0000_0013, 1'b0, 5'd0, 64'd0, 1'b0);
    bus.in_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checks++; if (bus.cmt_valid !== 1'b0 || bus.trap_valid !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL trap_frozen cyc %0d got cmt=%0b trap=%0b rdy=%0b want 0/0/0", k, bus.cmt_valid, bus.trap_valid, bus.in_ready); end
    end
    checks++; if (bus.cycle_cnt !== 64'd7) begin errors++; $display("FAIL trap_cycle_cnt got %0d want 7", bus.cycle_cnt); end
    checks++; if (bus.instr_cnt !== 64'd1) begin errors++; $display("FAIL trap_instr_cnt got %0d want 1", bus.instr_cnt); end
    do_reset();
    set_lane(0, 64'h8000_0020, 32'h0000_006b, 1'b0, 5'd0, 64'd0, 1'b0);
    bus.in_valid = 2'b01;
    bus.trap_code_i = 8'h5a;
    @(negedge clock);
    bus.in_valid = 2'b00;
    @(negedge clock);
    checks++; if (bus.trap_valid !== 1'b1 || bus.trap_pc !== 64'h8000_0020 || bus.trap_code !== 8'h5a) begin errors++; $display("FAIL trap2_pulse got v=%0b pc=%h code=%h want 1/80000020/5a", bus.trap_valid, bus.trap_pc, bus.trap_code); end
    @(negedge clock);
    checks++; if (bus.trap_valid !== 1'b0 || bus.trap_code !== 8'h5a) begin errors++; $display("FAIL trap2_after got v=%0b code=%h want 0/5a", bus.trap_valid, bus.trap_code); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_lane(0, 64'h8000_2000 + 64'(8 * k), 32'h0000_0013, 1'b0, 5'd0, 64'd0, 1'b0);
      set_lane(1, 64'h8000_2004 + 64'(8 * k), 32'h0000_0013, 1'b0, 5'd0, 64'd0, 1'b0);
      bus.in_valid = 2'b11;
      @(negedge clock);
    end
    clear_inputs();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (bus.cmt_valid !== 1'b0 || bus.cmt_pc !== 64'd0) begin errors++; $display("FAIL rmid_cmt got v=%0b pc=%h want 0/0", bus.cmt_valid, bus.cmt_pc); end
    checks++; if (bus.cycle_cnt !== 64'd0 || bus.instr_cnt !== 64'd0) begin errors++; $display("FAIL rmid_counters got cyc=%0d ins=%0d want 0/0", bus.cycle_cnt, bus.instr_cnt); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %0b want 1", bus.in_ready); end
    repeat (2) begin
      @(negedge clock);
      checks++; if (bus.cmt_valid !== 1'b0) begin errors++; $display("FAIL rmid_empty got %0b want 0", bus.cmt_valid); end
    end
    set_lane(0, 64'h8000_0100, 32'h0000_0013, 1'b0, 5'd0, 64'd0, 1'b1);
    set_lane(1, 64'h8000_0104, 32'h01f0_0f93, 1'b1, 5'd31, 64'hdead_beef_0000_0001, 1'b0);
    bus.in_valid = 2'b11;
    @(negedge clock);
    clear_inputs();
    @(negedge clock);
    checks++; if (bus.cmt_valid !== 1'b1 || bus.cmt_pc !== 64'h8000_0100 || bus.cmt_skip !== 1'b1) begin errors++; $display("FAIL rmid_rec0 got v=%0b pc=%h skip=%0b want 1/80000100/1", bus.cmt_valid, bus.cmt_pc, bus.cmt_skip); end
    @(negedge clock);
    checks++; if (bus.cmt_pc !== 64'h8000_0104 || bus.cmt_wdest !== 8'd31 || bus.cmt_wdata !== 64'hdead_beef_0000_0001 || bus.cmt_skip !== 1'b0) begin errors++; $display("FAIL rmid_rec1 got pc=%h wdest=%0d wdata=%h skip=%0b want 80000104/31/deadbeef00000001/0", bus.cmt_pc, bus.cmt_wdest, bus.cmt_wdata, bus.cmt_skip); end
    checks++; if (bus.instr_cnt !== 64'd2 || bus.cycle_cnt !== 64'd5) begin errors++; $display("FAIL rmid_counts got ins=%0d cyc=%0d want 2/5", bus.instr_cnt, bus.cycle_cnt); end
  endtask

  task automatic test_wdog();
    do_reset();
`ifdef COMMIT_WDOG_EN
    repeat (65534) @(negedge clock);
    checks++; if (bus.wdog_timeout !== 1'b0) begin errors++; $display("FAIL wdog_early got %0b want 0", bus.wdog_timeout); end
    @(negedge clock);
    checks++; if (bus.wdog_timeout !== 1'b1) begin errors++; $display("FAIL wdog_fire got %0b want 1", bus.wdog_timeout); end
    repeat (10) @(negedge clock);
    checks++; if (bus.wdog_timeout !== 1'b1) begin errors++; $display("FAIL wdog_sticky got %0b want 1", bus.wdog_timeout); end
`else
    repeat (300) @(negedge clock);
    checks++; if (bus.wdog_timeout !== 1'b0) begin errors++; $display("FAIL wdog_off got %0b want 0", bus.wdog_timeout); end
`endif
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_basic();
    test_burst();
    test_alternate();
    test_trap();
    test_reset_mid();
    test_wdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
